bnn_output_layer_stream: RTL and testbench

- Parametrised, time-multiplexed successor to the combinational/registered 10-neuron output layer.
- Accepts one binarised feature vector through a valid/ready handshake. Streams weights from an external synchronous-read weight memory, CHUNK_W bits per cycle.
- Accumulates XNOR-popcount per class and tracks a running argmax.
- Returns the winning class index and its score through a valid/ready handshake. Sits between the last hidden BNN layer and the top-level result register.

---
 rtl/bnn_pkg.sv | 20 ++
 rtl/bnn_xnor_popcount.sv | 25 ++
 rtl/bnn_output_layer_stream.sv | 172 +++++++++++++++++
 tb/tb_bnn_output_layer_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and elaboration-time helpers for the binarised network layers.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } out_layer_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Counter/index widths never collapse to zero bits, even for a single entry.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational masked XNOR-popcount of one weight chunk against one data chunk.
module bnn_xnor_popcount #(
    parameter int CHUNK_W    = 28,
    parameter int VALID_BITS = 28,
    localparam int CNT_W     = $clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] data_chunk,
    input  logic [CHUNK_W-1:0] weight_chunk,
    input  logic               is_last,
    output logic [CNT_W-1:0]   count
);

    logic [CHUNK_W-1:0] match_s;

    assign match_s = ~(data_chunk ^ weight_chunk);

    // Padding positions of the final chunk never contribute to the count.
    always_comb begin
        count = {CNT_W{1'b0}};
        for (int i = 0; i < CHUNK_W; i++) begin
            count = count + CNT_W'(match_s[i] & (~is_last | (i < VALID_BITS)));
        end
    end

endmodule

// File: rtl/bnn_output_layer_stream.sv
// Time-multiplexed BNN output layer: streams weights chunk by chunk,
// accumulates per-class XNOR popcounts and reports the running argmax.
module bnn_output_layer_stream
    import bnn_pkg::*;
#(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_CLASSES = 10,
    parameter int CHUNK_W     = 28,
    localparam int NUM_CHUNKS = ceil_div(NUM_INPUTS, CHUNK_W),
    localparam int SCORE_W    = $clog2(NUM_INPUTS + 1),
    localparam int IDX_W      = clog2_min1(NUM_CLASSES),
    localparam int ADDR_W     = clog2_min1(NUM_CLASSES * NUM_CHUNKS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_INPUTS-1:0] data_in,
    output logic                  weight_en,
    output logic [ADDR_W-1:0]     weight_addr,
    input  logic [CHUNK_W-1:0]    weight_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      answer,
    output logic [SCORE_W-1:0]    score
);

    localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
    localparam int LAST_VALID = NUM_INPUTS - (NUM_CHUNKS - 1) * CHUNK_W;
    localparam int CNT_W      = $clog2(CHUNK_W + 1);
    localparam int CHK_W      = clog2_min1(NUM_CHUNKS);
    localparam logic [CHK_W-1:0] LAST_CHK = CHK_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] LAST_CLS = IDX_W'(NUM_CLASSES - 1);

    out_layer_state_t   state_r;
    logic [PAD_W-1:0]   data_r;
    logic [IDX_W-1:0]   cls_r;
    logic [CHK_W-1:0]   chk_r;

    logic               beat_valid_r;
    logic [IDX_W-1:0]   beat_cls_r;
    logic [CHK_W-1:0]   beat_chk_r;
    logic               beat_last_r;

    logic [SCORE_W-1:0] acc_r;
    logic [SCORE_W-1:0] best_score_r;
    logic [IDX_W-1:0]   best_idx_r;

    logic [CHUNK_W-1:0] data_chunk_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [SCORE_W-1:0] acc_base_s;
    logic [SCORE_W-1:0] total_s;
    logic [SCORE_W-1:0] best_score_nxt_s;
    logic [IDX_W-1:0]   best_idx_nxt_s;

    assign data_chunk_s = data_r[int'(beat_chk_r) * CHUNK_W +: CHUNK_W];
    assign acc_base_s   = (beat_chk_r == {CHK_W{1'b0}}) ? {SCORE_W{1'b0}} : acc_r;
    assign total_s      = acc_base_s + SCORE_W'(cnt_s);

    bnn_xnor_popcount #(
        .CHUNK_W    (CHUNK_W),
        .VALID_BITS (LAST_VALID)
    ) u_popcount (
        .data_chunk   (data_chunk_s),
        .weight_chunk (weight_data),
        .is_last      (beat_last_r),
        .count        (cnt_s)
    );

    // Argmax candidate: class 0 always seeds the best, later classes must strictly beat it.
    always_comb begin
        best_score_nxt_s = best_score_r;
        best_idx_nxt_s   = best_idx_r;
        if (beat_valid_r && beat_last_r &&
            (beat_cls_r == {IDX_W{1'b0}} || total_s > best_score_r)) begin
            best_score_nxt_s = total_s;
            best_idx_nxt_s   = beat_cls_r;
        end else begin
            best_score_nxt_s = best_score_r;
            best_idx_nxt_s   = best_idx_r;
        end
    end

    // Control FSM with handshake, address issue and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            data_r      <= {PAD_W{1'b0}};
            cls_r       <= {IDX_W{1'b0}};
            chk_r       <= {CHK_W{1'b0}};
            in_ready    <= 1'b1;
            weight_en   <= 1'b0;
            weight_addr <= {ADDR_W{1'b0}};
            out_valid   <= 1'b0;
            answer      <= {IDX_W{1'b0}};
            score       <= {SCORE_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        data_r      <= PAD_W'(data_in);
                        cls_r       <= {IDX_W{1'b0}};
                        chk_r       <= {CHK_W{1'b0}};
                        in_ready    <= 1'b0;
                        weight_en   <= 1'b1;
                        weight_addr <= {ADDR_W{1'b0}};
                        state_r     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cls_r == LAST_CLS && chk_r == LAST_CHK) begin
                        weight_en   <= 1'b0;
                        weight_addr <= {ADDR_W{1'b0}};
                        state_r     <= S_DRAIN;
                    end else begin
                        weight_addr <= weight_addr + ADDR_W'(1);
                        if (chk_r == LAST_CHK) begin
                            chk_r <= {CHK_W{1'b0}};
                            cls_r <= cls_r + IDX_W'(1);
                        end else begin
                            chk_r <= chk_r + CHK_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // The last beat lands this cycle, so take the freshly updated best.
                    answer    <= best_idx_nxt_s;
                    score     <= best_score_nxt_s;
                    out_valid <= 1'b1;
                    state_r   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    weight_en <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    // Beat tags follow the synchronous read by one cycle; accumulate and track best.
    always_ff @(posedge clock) begin
        if (!reset) begin
            beat_valid_r <= 1'b0;
            beat_cls_r   <= {IDX_W{1'b0}};
            beat_chk_r   <= {CHK_W{1'b0}};
            beat_last_r  <= 1'b0;
            acc_r        <= {SCORE_W{1'b0}};
            best_score_r <= {SCORE_W{1'b0}};
            best_idx_r   <= {IDX_W{1'b0}};
        end else begin
            beat_valid_r <= weight_en;
            beat_cls_r   <= cls_r;
            beat_chk_r   <= chk_r;
            beat_last_r  <= (chk_r == LAST_CHK);
            if (beat_valid_r) begin
                acc_r        <= total_s;
                best_score_r <= best_score_nxt_s;
                best_idx_r   <= best_idx_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_bnn_output_layer_stream.sv
// Randomised bench: a direct per-class popcount/argmax model scores every vector
// for a default-sized layer and a small padded layer.
module tb_bnn_output_layer_stream;

    localparam int NI = 196, NC = 10, CW = 28, NCH = 7, TOT = 70;
    localparam int SW = 8, IW = 4, AW = 7;
    localparam int SNI = 30, SNC = 3, SCW = 8, SNCH = 4, STOT = 12;
    localparam int SSW = 5, SIW = 2, SAW = 4;

    logic clock;
    logic reset;
    logic in_valid, in_ready, weight_en, out_valid, out_ready;
    logic [NI-1:0] data_in;
    logic [AW-1:0] weight_addr;
    logic [CW-1:0] weight_data;
    logic [IW-1:0] answer;
    logic [SW-1:0] score;
    logic [CW-1:0] mem [TOT];

    logic s_in_valid, s_in_ready, s_weight_en, s_out_valid, s_out_ready;
    logic [SNI-1:0] s_data_in;
    logic [SAW-1:0] s_weight_addr;
    logic [SCW-1:0] s_weight_data;
    logic [SIW-1:0] s_answer;
    logic [SSW-1:0] s_score;
    logic [SCW-1:0] s_mem [STOT];

    int n_vec = 0;
    int n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    bnn_output_layer_stream dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .weight_en(weight_en), .weight_addr(weight_addr),
        .weight_data(weight_data), .out_valid(out_valid), .out_ready(out_ready),
        .answer(answer), .score(score)
    );

    bnn_output_layer_stream #(.NUM_INPUTS(SNI), .NUM_CLASSES(SNC), .CHUNK_W(SCW)) dut_small (
        .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .data_in(s_data_in), .weight_en(s_weight_en), .weight_addr(s_weight_addr),
        .weight_data(s_weight_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .answer(s_answer), .score(s_score)
    );

    always @(posedge clock) begin
        if (weight_en) weight_data <= mem[weight_addr];
        if (s_weight_en) s_weight_data <= s_mem[s_weight_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NI-1:0] rand_vec();
        logic [NI-1:0] v;
        for (int i = 0; i < NI; i++) v[i] = 1'($urandom);
        return v;
    endfunction

    // Weight of input bit i for class c sits at word c*NCH + i/CW, bit i%CW.
    function automatic int ref_score(input logic [NI-1:0] d, input int c);
        int s;
        s = 0;
        for (int i = 0; i < NI; i++) s += (d[i] == mem[c*NCH + i/CW][i%CW]) ? 1 : 0;
        return s;
    endfunction

    function automatic int s_ref_score(input logic [SNI-1:0] d, input int c);
        int s;
        s = 0;
        for (int i = 0; i < SNI; i++) s += (d[i] == s_mem[c*SNCH + i/SCW][i%SCW]) ? 1 : 0;
        return s;
    endfunction

    task automatic store_class(input int c, input logic [NI-1:0] w);
        logic [NCH*CW-1:0] p;
        p = {NCH*CW{1'b0}};
        p[NI-1:0] = w;
        for (int j = 0; j < NCH; j++) mem[c*NCH + j] = p[j*CW +: CW];
    endtask

    task automatic random_weights();
        for (int c = 0; c < NC; c++) store_class(c, rand_vec());
    endtask

    // Starts at a negedge in IDLE; ends at the negedge where in_ready is back.
    task automatic run_vector(input logic [NI-1:0] d, input int hold, input logic tie_ready);
        int exp_idx, exp_sc, sc;
        exp_idx = 0;
        exp_sc  = ref_score(d, 0);
        for (int k = 1; k < NC; k++) begin
            sc = ref_score(d, k);
            if (sc > exp_sc) begin
                exp_sc  = sc;
                exp_idx = k;
            end
        end
        check_eq("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        data_in  = d;
        for (int c = 1; c <= TOT + 2; c++) begin
            @(negedge clock);
            check_eq("weight_en", weight_en, (c <= TOT) ? 1 : 0);
            if (c <= TOT) check_eq("weight_addr", weight_addr, c - 1);
            check_eq("out_valid_timing", out_valid, (c == TOT + 2) ? 1 : 0);
            check_eq("in_ready_busy", in_ready, 0);
            in_valid = (c < TOT) ? 1'($urandom) : 1'b0;
            data_in  = rand_vec();
        end
        check_eq("answer", answer, exp_idx);
        check_eq("score", score, exp_sc);
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_answer", answer, exp_idx);
            check_eq("hold_score", score, exp_sc);
            check_eq("hold_in_ready", in_ready, 0);
            in_valid = 1'($urandom);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check_eq("out_valid_drop", out_valid, 0);
        check_eq("in_ready_back", in_ready, 1);
        out_ready = tie_ready;
    endtask

    task automatic abort_run(input logic [NI-1:0] d);
        check_eq("abort_in_ready", in_ready, 1);
        in_valid = 1'b1;
        data_in  = d;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (29) @(negedge clock);
        check_eq("abort_mid_en", weight_en, 1);
        check_eq("abort_mid_addr", weight_addr, 29);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_eq("abort_weight_en", weight_en, 0);
        check_eq("abort_weight_addr", weight_addr, 0);
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_answer", answer, 0);
        check_eq("abort_score", score, 0);
    endtask

    task automatic run_small(input logic [SNI-1:0] d);
        int exp_idx, exp_sc, sc, lat;
        exp_idx = 0;
        exp_sc  = s_ref_score(d, 0);
        for (int k = 1; k < SNC; k++) begin
            sc = s_ref_score(d, k);
            if (sc > exp_sc) begin
                exp_sc  = sc;
                exp_idx = k;
            end
        end
        check_eq("s_in_ready", s_in_ready, 1);
        s_in_valid = 1'b1;
        s_data_in  = d;
        lat = 0;
        do begin
            @(negedge clock);
            s_in_valid = 1'b0;
            lat++;
        end while (!s_out_valid && lat < 40);
        check_eq("s_latency", lat, STOT + 2);
        check_eq("s_answer", s_answer, exp_idx);
        check_eq("s_score", s_score, exp_sc);
        s_out_ready = 1'b1;
        @(negedge clock);
        s_out_ready = 1'b0;
        check_eq("s_in_ready_back", s_in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NI-1:0] d;
        logic [NI-1:0] ones;
        ones = {NI{1'b1}};
        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; data_in = {NI{1'b0}};
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_data_in = {SNI{1'b0}};
        repeat (3) @(negedge clock);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_weight_en", weight_en, 0);
        check_eq("rst_weight_addr", weight_addr, 0);
        check_eq("rst_answer", answer, 0);
        check_eq("rst_score", score, 0);
        reset = 1'b1;
        @(negedge clock);

        // Only class 3 matches an all-ones input.
        for (int c = 0; c < NC; c++) store_class(c, (c == 3) ? ones : {NI{1'b0}});
        run_vector(ones, 0, 1'b0);

        // Classes 2 and 7 tie at full score; the lower index wins. Held output.
        d = rand_vec();
        for (int c = 0; c < NC; c++) store_class(c, (c == 2 || c == 7) ? d : ~d);
        run_vector(d, 5, 1'b0);

        // Mid-run reset aborts, then a fresh vector completes.
        random_weights();
        abort_run(rand_vec());
        random_weights();
        run_vector(rand_vec(), 0, 1'b0);

        // Back-to-back with out_ready tied high; second run scores lower.
        out_ready = 1'b1;
        for (int c = 0; c < NC; c++) store_class(c, (c == 3) ? ones : {NI{1'b0}});
        run_vector(ones, 0, 1'b1);
        for (int c = 0; c < NC; c++) store_class(c, {NI{1'b0}});
        run_vector(ones, 0, 1'b1);
        random_weights();
        run_vector(rand_vec(), 0, 1'b1);
        random_weights();
        run_vector(rand_vec(), 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            random_weights();
            run_vector(rand_vec(), int'($urandom_range(0, 3)), 1'b0);
        end

        // Small layer: padding bits of the last chunk are set but must not count.
        for (int j = 0; j < STOT; j++) s_mem[j] = 8'hFF;
        run_small({SNI{1'b1}});
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < STOT; j++) s_mem[j] = 8'($urandom);
            run_small(SNI'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
